// File: rtl/fetch_unit_pkg.sv
// Shared pipeline types for the fetch stage.
// Holds the IF/ID bundle, fetch FSM states and opcodes.
package fetch_unit_pkg;

  localparam int IF_ADDR_W  = 16;
  localparam int IF_INSTR_W = 16;

  localparam logic [3:0] OP_HLT = 4'b1111;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;

  typedef enum logic [1:0] {
    FETCH,
    DRAIN,
    HALT
  } fetch_state_e;

  typedef struct packed {
    logic [IF_INSTR_W-1:0] instr;
    logic [IF_ADDR_W-1:0]  pc_plus2;
    logic                  valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '0;

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register.
// Squash beats load; neither means hold.
module fetch_unit_if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load_i,
  input  logic   squash_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // capture, squash to bubble, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= IF_ID_BUBBLE;
    end else if (squash_i) begin
      q_q <= IF_ID_BUBBLE;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM, IF/ID.
// Redirects during a miss wait in DRAIN for the fill.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int          ADDR_W     = IF_ADDR_W,
  parameter int          INSTR_W    = IF_INSTR_W,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = OP_HLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_decode,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] d_instr,
  output logic [ADDR_W-1:0]  d_pc_plus2,
  output logic               d_valid,
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] redir_q, redir_d;
  logic [ADDR_W-1:0] pc_plus2;
  logic              is_hlt;
  logic              load;
  logic              squash;
  if_id_t            if_id_in;
  if_id_t            if_id_q;

  assign pc_plus2 = pc_q + ADDR_W'(2);
  assign is_hlt   = (imem_rdata[INSTR_W-1 -: 4] == HLT_OPCODE);

  assign if_id_in = '{
    instr:    imem_rdata,
    pc_plus2: pc_plus2,
    valid:    1'b1
  };

  // next state; priority flush > stall > accept
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    load    = 1'b0;
    squash  = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (flush) begin
          squash = 1'b1;
          if (imem_valid) begin
            pc_d = branch_target;
          end else begin
            redir_d = branch_target;
            state_d = DRAIN;
          end
        end else if (!stall_decode && imem_valid) begin
          load = 1'b1;
          if (is_hlt) begin
            state_d = HALT;
          end else begin
            pc_d = pc_plus2;
          end
        end
      end
      DRAIN: begin
        squash = flush || !stall_decode;
        if (flush) begin
          redir_d = branch_target;
        end
        if (imem_valid) begin
          pc_d    = flush ? branch_target : redir_q;
          state_d = FETCH;
        end
      end
      HALT: begin
        if (flush) begin
          squash  = 1'b1;
          pc_d    = branch_target;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // PC, FSM state and pending redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
    end
  end

  fetch_unit_if_id_reg u_if_id (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .squash_i (squash),
    .d_i      (if_id_in),
    .q_o      (if_id_q)
  );

  assign imem_req   = (state_q != HALT);
  assign imem_addr  = pc_q;
  assign halted     = (state_q == HALT);
  assign d_instr    = if_id_q.instr;
  assign d_pc_plus2 = if_id_q.pc_plus2;
  assign d_valid    = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit.
// Expected IF/ID contents queued per step.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_decode;
  logic        flush;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] d_instr;
  logic [15:0] d_pc_plus2;
  logic        d_valid;
  logic        halted;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_decode  (stall_decode),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .d_instr       (d_instr),
    .d_pc_plus2    (d_pc_plus2),
    .d_valid       (d_valid),
    .halted        (halted)
  );

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] i,
                      input logic [15:0] p,
                      input logic v);
    exp_t e;
    e.instr = i;
    e.pc2   = p;
    e.valid = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s obs=empty exp=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".instr"}, d_instr, e.instr);
      chk({tag, ".pc2"}, d_pc_plus2, e.pc2);
      chk({tag, ".valid"}, 16'(d_valid), 16'(e.valid));
    end
  endtask

  // one clock: drive, check fetch address, clock, settle
  task automatic cyc(input logic v,
                     input logic [15:0] rd,
                     input logic st,
                     input logic fl,
                     input logic [15:0] bt,
                     input logic [15:0] exp_addr);
    @(negedge clk);
    imem_valid    = v;
    imem_rdata    = rd;
    stall_decode  = st;
    flush         = fl;
    branch_target = bt;
    #1;
    chk("imem_addr", imem_addr, exp_addr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_decode = 1'b0;
    flush = 1'b0;
    branch_target = '0;
    imem_valid = 1'b0;
    imem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    push(16'h0, 16'h0, 1'b0);
    pop_chk("reset");
    chk("reset.halted", 16'(halted), 16'h0);
    chk("reset.req", 16'(imem_req), 16'h1);
    chk("reset.addr", imem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    cyc(1, 16'h1234, 0, 0, 0, 16'h0000);
    push(16'h1234, 16'h0002, 1); pop_chk("hit0");
    cyc(1, 16'h2345, 0, 0, 0, 16'h0002);
    push(16'h2345, 16'h0004, 1); pop_chk("hit1");
    cyc(1, 16'h0101, 0, 1, 16'h0010, 16'h0004);
    push(16'h0, 16'h0, 0); pop_chk("flush10");

    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0000, 0, 0, 0, 16'h0010);
      push(16'h0, 16'h0, 0); pop_chk("miss");
    end
    cyc(1, 16'hA001, 0, 0, 0, 16'h0010);
    push(16'hA001, 16'h0012, 1); pop_chk("missdone");

    for (int i = 0; i < 2; i++) begin
      cyc(1, 16'h3333, 1, 0, 0, 16'h0012);
      push(16'hA001, 16'h0012, 1); pop_chk("stall");
    end
    cyc(1, 16'h3333, 0, 0, 0, 16'h0012);
    push(16'h3333, 16'h0014, 1); pop_chk("unstall");
    cyc(1, 16'h0102, 0, 1, 16'h0020, 16'h0014);
    push(16'h0, 16'h0, 0); pop_chk("flush20");

    cyc(0, 16'h0, 0, 0, 0, 16'h0020);
    push(16'h0, 16'h0, 0); pop_chk("m20.0");
    cyc(0, 16'h0, 0, 1, 16'h0100, 16'h0020);
    push(16'h0, 16'h0, 0); pop_chk("m20.fl");
    cyc(0, 16'h0, 0, 0, 0, 16'h0020);
    push(16'h0, 16'h0, 0); pop_chk("drain");
    cyc(1, 16'hBEEF, 0, 0, 0, 16'h0020);
    push(16'h0, 16'h0, 0); pop_chk("drop");
    cyc(1, 16'h4444, 0, 0, 0, 16'h0100);
    push(16'h4444, 16'h0102, 1); pop_chk("hit100");

    cyc(0, 16'h0, 0, 1, 16'h0180, 16'h0102);
    push(16'h0, 16'h0, 0); pop_chk("d1");
    cyc(0, 16'h0, 0, 1, 16'h0200, 16'h0102);
    push(16'h0, 16'h0, 0); pop_chk("d2");
    cyc(1, 16'hBEEF, 0, 0, 0, 16'h0102);
    push(16'h0, 16'h0, 0); pop_chk("d3");
    cyc(0, 16'h0, 0, 1, 16'h0300, 16'h0200);
    push(16'h0, 16'h0, 0); pop_chk("d4");
    cyc(1, 16'hBEEF, 0, 1, 16'h0030, 16'h0200);
    push(16'h0, 16'h0, 0); pop_chk("d5");

    cyc(1, 16'hF000, 0, 0, 0, 16'h0030);
    push(16'hF000, 16'h0032, 1); pop_chk("hlt");
    chk("hlt.halted", 16'(halted), 16'h1);
    chk("hlt.req", 16'(imem_req), 16'h0);
    cyc(1, 16'h5555, 0, 0, 0, 16'h0030);
    push(16'hF000, 16'h0032, 1); pop_chk("hlt.hold");
    chk("hlt.halted2", 16'(halted), 16'h1);
    cyc(0, 16'h0, 0, 1, 16'h0040, 16'h0030);
    push(16'h0, 16'h0, 0); pop_chk("unhalt");
    chk("unhalt.halted", 16'(halted), 16'h0);
    chk("unhalt.req", 16'(imem_req), 16'h1);
    cyc(1, 16'h6666, 0, 0, 0, 16'h0040);
    push(16'h6666, 16'h0042, 1); pop_chk("hit40");

    cyc(1, 16'h7777, 1, 1, 16'hFFFE, 16'h0042);
    push(16'h0, 16'h0, 0); pop_chk("flstall");
    cyc(1, 16'h8888, 0, 0, 0, 16'hFFFE);
    push(16'h8888, 16'h0000, 1); pop_chk("wrap");
    chk("wrap.addr", imem_addr, 16'h0000);

    cyc(0, 16'h0, 0, 1, 16'h0500, 16'h0000);
    push(16'h0, 16'h0, 0); pop_chk("rstdrain");
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    imem_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid.addr", imem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 16'h9999, 0, 0, 0, 16'h0000);
    push(16'h9999, 16'h0002, 1); pop_chk("postrst");
    chk("postrst.addr", imem_addr, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipeline; owns the PC and the IF/ID pipeline register.
- Issues requests to the instruction cache over a req/valid handshake; misses take multiple cycles.
- Consumes the hazard unit's stall_decode and flush (branch redirect) outputs.
- Handles HLT detection and redirects that arrive while a miss is outstanding.

Parameters:
ADDR_W, 16, PC / instruction address width
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
HLT_OPCODE, 4'b1111, opcode (instr[15:12]) that halts fetch

Ports:
clk  input  1  single clock; one clock clk, reset rst is synchronous and active-high
rst  input  1  synchronous, active-high reset
stall_decode  input  1  hold IF/ID and PC (from hazard unit)
flush  input  1  branch taken in decode; squash IF/ID, redirect PC
branch_target  input  ADDR_W  redirect address, valid when flush=1
imem_req  output  1  fetch request to instruction cache
imem_addr  output  ADDR_W  fetch address; equals pc
imem_valid  input  1  imem_rdata valid this cycle (hit same cycle, or miss completion)
imem_rdata  input  INSTR_W  fetched instruction
d_instr  output  INSTR_W  IF/ID instruction
d_pc_plus2  output  ADDR_W  IF/ID PC+2
d_valid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  fetch halted on HLT

Behaviour:
- Reset (rst=1 at posedge):
  - pc=RESET_PC, state=FETCH, redirect_pc=0.
  - d_instr=0, d_pc_plus2=0, d_valid=0, halted=0.
- States: FETCH, DRAIN, HALT. Outputs are combinational from state:
  - imem_req = (state != HALT).
  - imem_addr = pc.
  - halted = (state == HALT).
- Handshake rules:
  - imem_addr must not change while imem_req=1 and imem_valid=0 (miss outstanding).
  - Data is consumed only in the cycle where imem_valid=1.
  - If data is not consumed, the request stays asserted at the same address and the cache returns it again.
- accept = (state==FETCH) & imem_valid & ~stall_decode & ~flush.
- Per-cycle priority: rst > flush > stall_decode > accept.
- FETCH:
  - accept:
    - IF/ID <= {imem_rdata, pc+2, valid=1}.
    - If imem_rdata[15:12]==HLT_OPCODE: pc holds at the HLT address and state goes to HALT.
    - Otherwise pc <= pc+2.
  - flush & imem_valid: IF/ID <= bubble (instr=0, pc_plus2=0, valid=0); returned data dropped; pc <= branch_target; stay in FETCH.
  - flush & ~imem_valid (miss outstanding): IF/ID <= bubble; redirect_pc <= branch_target; go to DRAIN.
  - stall_decode & ~flush: IF/ID, pc and state all hold, whether or not imem_valid is asserted.
  - ~imem_valid, no flush: all hold (miss wait). d_valid keeps its value; decode advancement is gated by the hazard unit.
- DRAIN:
  - imem_req=1, imem_addr = old pc.
  - IF/ID stays bubble unless stall_decode holds it.
  - flush again: redirect_pc <= newest branch_target.
  - imem_valid: data dropped; pc <= redirect_pc, or branch_target if flush is asserted the same cycle; go to FETCH.
- HALT:
  - imem_req=0; pc and IF/ID hold.
  - flush (HLT was on a wrong path): IF/ID <= bubble; pc <= branch_target; go to FETCH.
- Arithmetic: pc+2 is modulo 2^ADDR_W; 16'hFFFE+2 wraps to 0.
- Latency: a hit delivers the instruction to IF/ID at the next edge, i.e. one fetch per cycle with no bubbles; an N-cycle miss inserts N-1 extra hold cycles.
- Reset mid-miss: state returns to FETCH at RESET_PC and any pending redirect is discarded. The cache must drop its in-flight fill when it sees the address change with rst.

Decomposition:
- Shared pipeline package:
  - HLT_OPCODE and the branch opcodes 4'b1100/4'b1101.
  - the fetch state enum {FETCH, DRAIN, HALT}.
  - the IF/ID bundle typedef {instr, pc_plus2, valid}.
  - the bubble constant.
- One natural sub-module: if_id_reg (IF/ID register with hold and squash inputs).
- PC, state machine and redirect_pc stay in fetch_unit.

Test Plan:
- Hits every cycle from reset, instructions 0x1234 then 0x2345 -> d_instr=0x1234 with d_pc_plus2=0x0002, then 0x2345 with 0x0004; imem_addr sequence 0,2,4.
- imem_valid low 3 cycles at pc=0x0010, then 0xA001 -> imem_addr stable at 0x0010 for all 4 cycles; single capture; pc=0x0012.
- stall_decode=1 for 2 cycles with imem_valid=1 -> d_instr and pc unchanged; capture happens on the first non-stall cycle.
- Miss at pc=0x0020, flush with target 0x0100 in cycle 1, miss completes in cycle 3 -> DRAIN for 2 cycles, addr held at 0x0020, data dropped, d_valid=0; next request at 0x0100. Repeat with a second flush to 0x0200 during DRAIN -> fetch resumes at 0x0200.
- HLT (0xF000) at pc=0x0030 -> halted=1, imem_req=0, pc=0x0030; a later flush to 0x0040 clears halted and fetches 0x0040.
- flush and stall_decode asserted together -> bubble loaded (d_valid=0), pc=branch_target; pc=0xFFFE accept -> pc wraps to 0x0000.
